// File: rtl/uart_rx_line.sv
// UART receiver with a CR/LF-terminated line assembler.
// Deserialises rx into bytes with optional parity and framing checks.
// Good bytes are gathered into a line buffer, and the buffer is handed to the
// consumer through a valid/ack handshake.
module uart_rx_line #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int LINE_BYTES = 7
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rx,
    output logic [7:0]                        rx_data,
    output logic                              rx_valid,
    output logic                              parity_err,
    output logic                              frame_err,
    output logic [8*LINE_BYTES-1:0]           line_data,
    output logic [$clog2(LINE_BYTES+1)-1:0]   line_len,
    output logic                              line_valid,
    input  logic                              line_ack,
    output logic                              line_trunc,
    output logic                              line_overrun
);

    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int CNTW = $clog2(DIV + 1);
    localparam int LENW = $clog2(LINE_BYTES + 1);

    localparam logic [CNTW-1:0] DIV_C    = CNTW'(DIV);
    localparam logic [CNTW-1:0] HALF_C   = CNTW'(DIV / 2);
    localparam logic [CNTW-1:0] ONE_C    = CNTW'(1);
    localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [LENW-1:0] FULL_C   = LENW'(LINE_BYTES);
    localparam logic [LENW-1:0] LEN_ONE  = LENW'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;

    // The parity check is true when the received parity bit disagrees with the data.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        logic ones;
        ones = (^d) ^ p;
        if (PARITY == 1) begin
            return ~ones;
        end
        return ones;
    endfunction

    state_t                 state, state_n;
    logic [CNTW-1:0]        cnt, cnt_n;
    logic [2:0]             bitc, bit_n;
    logic [DATA_BITS-1:0]   sh, sh_n;
    logic                   perr, perr_n;
    logic                   good_s, perr_s, ferr_s;
    logic                   rx_meta, rx_s, rx_s_d;
    logic                   fall, tick;
    logic [7:0]             byte_ext;

    logic                   vld_p1;
    logic [7:0]             byte_p1;
    logic                   term;
    logic [LENW-1:0]        count;
    logic [8*LINE_BYTES-1:0] acc;
    logic [8*LINE_BYTES-1:0] line_cap;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection. It idles at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    assign fall = rx_s_d & ~rx_s;
    assign tick = (cnt == ONE_C);

    // FSM state register and the bit-timing counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            bitc  <= '0;
            perr  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bitc  <= bit_n;
            perr  <= perr_n;
        end
    end

    // Shift register for the incoming data bits. Its contents only matter after a full frame.
    always_ff @(posedge clk) begin
        sh <= sh_n;
    end

    // Next-state logic: sample each bit at its expiry and flag the end-of-frame outcome.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bitc;
        sh_n    = sh;
        perr_n  = perr;
        good_s  = 1'b0;
        perr_s  = 1'b0;
        ferr_s  = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    cnt_n   = HALF_C;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n   = DIV_C;
                        bit_n   = '0;
                        perr_n  = 1'b0;
                        state_n = DATA;
                    end
                end else begin
                    cnt_n = cnt - ONE_C;
                end
            end
            DATA: begin
                if (tick) begin
                    sh_n  = {rx_s, sh[DATA_BITS-1:1]};
                    cnt_n = DIV_C;
                    if (bitc == LAST_BIT) begin
                        state_n = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_n = bitc + 3'd1;
                    end
                end else begin
                    cnt_n = cnt - ONE_C;
                end
            end
            PAR: begin
                if (tick) begin
                    perr_n  = parity_bad(sh, rx_s);
                    cnt_n   = DIV_C;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt - ONE_C;
                end
            end
            STOP: begin
                if (tick) begin
                    if (!rx_s) begin
                        ferr_s  = 1'b1;
                        state_n = WAIT_HI;
                    end else if (perr) begin
                        perr_s  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        good_s  = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - ONE_C;
                end
            end
            WAIT_HI: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Zero-extend the received word to a byte.
    always_comb begin
        byte_ext                = '0;
        byte_ext[DATA_BITS-1:0] = sh;
    end

    // Byte output stage: the status pulses are registered one cycle after the stop sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            byte_p1    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            vld_p1     <= good_s;
            parity_err <= perr_s;
            frame_err  <= ferr_s;
            if (good_s) begin
                byte_p1 <= byte_ext;
            end
        end
    end

    assign rx_valid = vld_p1;
    assign rx_data  = byte_p1;
    assign term     = (byte_p1 == 8'h0A) || (byte_p1 == 8'h0D);

    // Snapshot of the accumulator with the slots above count zeroed, so stale bytes never leak.
    always_comb begin
        line_cap = '0;
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (LENW'(i) < count) begin
                line_cap[i*8 +: 8] = acc[i*8 +: 8];
            end
        end
    end

    // Line accumulator storage: holds data only, and count decides which slots are live.
    always_ff @(posedge clk) begin
        if (vld_p1 && !term) begin
            for (int i = 0; i < LINE_BYTES; i++) begin
                if (count == LENW'(i)) begin
                    acc[i*8 +: 8] <= byte_p1;
                end
            end
        end
    end

    // Line control: handle the handshake, complete lines on a terminator, and detect truncation or overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            line_valid   <= 1'b0;
            line_len     <= '0;
            line_data    <= '0;
            line_trunc   <= 1'b0;
            line_overrun <= 1'b0;
        end else begin
            line_trunc   <= 1'b0;
            line_overrun <= 1'b0;
            if (line_valid && line_ack) begin
                line_valid <= 1'b0;
            end
            if (vld_p1) begin
                if (term) begin
                    if (count != '0) begin
                        if (!line_valid || line_ack) begin
                            line_data  <= line_cap;
                            line_len   <= count;
                            line_valid <= 1'b1;
                        end else begin
                            line_overrun <= 1'b1;
                        end
                        count <= '0;
                    end
                end else if (count < FULL_C) begin
                    count <= count + LEN_ONE;
                end else begin
                    line_trunc <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_line.sv
// Directed bench for uart_rx_line.
// Instance A uses no parity and 7 line bytes. Instance B uses even parity and 4 line bytes.
// Both run with DIV = 10 clocks per bit.
module tb_uart_rx_line;

    localparam int CF  = 1000000;
    localparam int BD  = 100000;
    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1;
    logic ack_a = 1'b0, ack_b = 1'b0;

    logic [7:0]  rxd_a, rxd_b;
    logic        rxv_a, rxv_b, perr_a, perr_b, ferr_a, ferr_b;
    logic [55:0] ld_a;
    logic [31:0] ld_b;
    logic [2:0]  ll_a, ll_b;
    logic        lv_a, lv_b, tr_a, tr_b, ov_a, ov_b;

    int nchecks = 0;
    int nerrors = 0;

    int nv_a = 0, nf_a = 0, np_a = 0, nt_a = 0, no_a = 0, nl_a = 0;
    int nv_b = 0, nf_b = 0, np_b = 0, nt_b = 0, no_b = 0, nl_b = 0;
    logic [7:0] hist_a [64];
    logic lvp_a = 1'b0, lvp_b = 1'b0;
    bit found = 1'b0;

    always #5 clk = ~clk;

    uart_rx_line #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY(0), .LINE_BYTES(7)) u_dut_a (
        .clk(clk), .rst(rst), .rx(rx_a),
        .rx_data(rxd_a), .rx_valid(rxv_a), .parity_err(perr_a), .frame_err(ferr_a),
        .line_data(ld_a), .line_len(ll_a), .line_valid(lv_a), .line_ack(ack_a),
        .line_trunc(tr_a), .line_overrun(ov_a)
    );

    uart_rx_line #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY(2), .LINE_BYTES(4)) u_dut_b (
        .clk(clk), .rst(rst), .rx(rx_b),
        .rx_data(rxd_b), .rx_valid(rxv_b), .parity_err(perr_b), .frame_err(ferr_b),
        .line_data(ld_b), .line_len(ll_b), .line_valid(lv_b), .line_ack(ack_b),
        .line_trunc(tr_b), .line_overrun(ov_b)
    );

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rxv_a) begin
            if (nv_a < 64) hist_a[nv_a] <= rxd_a;
            nv_a <= nv_a + 1;
        end
        if (ferr_a) nf_a <= nf_a + 1;
        if (perr_a) np_a <= np_a + 1;
        if (tr_a)   nt_a <= nt_a + 1;
        if (ov_a)   no_a <= no_a + 1;
        if (lv_a && !lvp_a) nl_a <= nl_a + 1;
        lvp_a <= lv_a;
        if (rxv_b)  nv_b <= nv_b + 1;
        if (ferr_b) nf_b <= nf_b + 1;
        if (perr_b) np_b <= np_b + 1;
        if (tr_b)   nt_b <= nt_b + 1;
        if (ov_b)   no_b <= no_b + 1;
        if (lv_b && !lvp_b) nl_b <= nl_b + 1;
        lvp_b <= lv_b;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_c(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send(input int sel, input logic [7:0] d, input bit use_par, input bit pbit, input bit stopb);
        drive(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive(sel, d[i]);
        if (use_par) drive(sel, pbit);
        drive(sel, stopb);
        if (stopb) drive(sel, 1'b1);
    endtask

    task automatic send_a(input logic [7:0] d);
        send(0, d, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send_b(input logic [7:0] d);
        send(1, d, 1'b1, ^d, 1'b1);
    endtask

    task automatic do_ack(input int sel);
        if (sel == 0) ack_a = 1'b1;
        else          ack_b = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        ack_b = 1'b0;
        #1;
        if (sel == 0) check("ack_clears_a", lv_a, 1'b0);
        else          check("ack_clears_b", lv_b, 1'b0);
    endtask

    initial begin
        // Reset state
        wait_c(4);
        check("rst_rx_valid", rxv_a, 0);
        check("rst_rx_data", rxd_a, 0);
        check("rst_errs", {perr_a, ferr_a, tr_a, ov_a}, 0);
        check("rst_line", {lv_a, ll_a}, 0);
        check("rst_line_data", ld_a, 0);
        check("rst_b_all", {rxv_b, rxd_b, perr_b, ferr_b, lv_b, ll_b, ld_b}, 0);
        rst = 1'b0;
        wait_c(5);

        // Test 1: "HI\r\n"
        send_a(8'h48); send_a(8'h49); send_a(8'h0D); send_a(8'h0A);
        wait_c(3);
        check("t1_nvalid", nv_a, 4);
        check("t1_b0", hist_a[0], 8'h48);
        check("t1_b1", hist_a[1], 8'h49);
        check("t1_b2", hist_a[2], 8'h0D);
        check("t1_b3", hist_a[3], 8'h0A);
        check("t1_nlines", nl_a, 1);
        check("t1_len", ll_a, 2);
        check("t1_data", ld_a, 56'h4948);
        check("t1_valid", lv_a, 1);
        do_ack(0);

        // Test 2: short low glitch is a false start
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        wait_c(30);
        check("t2_no_byte", nv_a, 4);
        check("t2_no_err", nf_a + np_a, 0);
        send_a(8'h41); send_a(8'h0A);
        wait_c(3);
        check("t2_nvalid", nv_a, 6);
        check("t2_byte", hist_a[4], 8'h41);
        check("t2_len", ll_a, 1);
        check("t2_data", ld_a, 56'h41);
        do_ack(0);

        // Test 3: bad stop followed by held-low break
        send(0, 8'h55, 1'b0, 1'b0, 1'b0);
        wait_c(30);
        check("t3_one_ferr", nf_a, 1);
        check("t3_no_byte", nv_a, 6);
        rx_a = 1'b1;
        wait_c(20);
        check("t3_still_one_ferr", nf_a, 1);
        send_a(8'h41); send_a(8'h0A);
        wait_c(3);
        check("t3_nvalid", nv_a, 8);
        check("t3_nlines", nl_a, 3);
        check("t3_len", ll_a, 1);
        check("t3_data", ld_a, 56'h41);
        do_ack(0);

        // Test 4: even parity on instance B
        send(1, 8'h07, 1'b1, 1'b0, 1'b1);
        wait_c(3);
        check("t4_perr", np_b, 1);
        check("t4_no_byte", nv_b, 0);
        check("t4_no_ferr", nf_b, 0);
        send_b(8'h07);
        wait_c(3);
        check("t4_nvalid", nv_b, 1);
        check("t4_data", rxd_b, 8'h07);
        check("t4_perr_once", np_b, 1);
        send_b(8'h0A);
        wait_c(3);
        check("t4_line", {ll_b, ld_b}, {3'd1, 32'h07});
        do_ack(1);

        // Test 5: truncation with a 4-byte buffer
        send_b(8'h41); send_b(8'h42); send_b(8'h43); send_b(8'h44); send_b(8'h45); send_b(8'h0A);
        wait_c(3);
        check("t5_trunc", nt_b, 1);
        check("t5_len", ll_b, 4);
        check("t5_data", ld_b, 32'h44434241);
        check("t5_nlines", nl_b, 2);
        check("t5_nvalid", nv_b, 8);

        // Test 6: overrun, then ack coinciding with a new line
        send_a(8'h41); send_a(8'h0A);
        wait_c(3);
        check("t6_first_line", {lv_a, ll_a, ld_a}, {1'b1, 3'd1, 56'h41});
        send_a(8'h42); send_a(8'h0A);
        wait_c(3);
        check("t6_overrun", no_a, 1);
        check("t6_kept_line", {lv_a, ll_a, ld_a}, {1'b1, 3'd1, 56'h41});
        check("t6_nlines", nl_a, 4);
        fork
            begin
                send_a(8'h43);
                send_a(8'h0A);
            end
            begin
                for (int k = 0; k < 400 && !found; k++) begin
                    @(negedge clk);
                    if (rxv_a && rxd_a == 8'h0A) begin
                        found = 1'b1;
                        ack_a = 1'b1;
                        @(negedge clk);
                        ack_a = 1'b0;
                    end
                end
            end
        join
        wait_c(3);
        check("t6_ack_seen", found, 1'b1);
        check("t6_new_wins", {lv_a, ll_a, ld_a}, {1'b1, 3'd1, 56'h43});
        check("t6_no_new_overrun", no_a, 1);

        // Reset in the middle of a frame with a partial line pending
        send_a(8'h51);
        drive(0, 1'b0); drive(0, 1'b1); drive(0, 1'b0);
        rst = 1'b1;
        rx_a = 1'b1;
        wait_c(3);
        check("rst2_outputs", {rxv_a, rxd_a, perr_a, ferr_a, tr_a, ov_a, lv_a, ll_a}, 0);
        check("rst2_line_data", ld_a, 0);
        check("rst2_b_line", {lv_b, ll_b, ld_b}, 0);
        rst = 1'b0;
        wait_c(200);
        check("rst2_no_spurious", nv_a, 15);
        check("rst2_no_ferr", nf_a, 1);
        send_a(8'h52); send_a(8'h0A);
        wait_c(3);
        check("rst2_fresh_line", {lv_a, ll_a, ld_a}, {1'b1, 3'd1, 56'h52});

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
